// File: rtl/pixel_pkg.sv
`default_nettype none
// pixel_pkg: pixel and chunk types shared by the filtering pipeline and output logic.
// Rev 1.0
package pixel_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam int CHUNK_PIXELS = 4;

  // Pixel 0 occupies the least-significant bits of the chunk.
  typedef pixel_t [CHUNK_PIXELS-1:0] chunk_t;

endpackage
`default_nettype wire

// File: rtl/axis_if.sv
`default_nettype none
// axis_if: valid/ready stream interface carrying one DATA_TYPE word per transfer.
// Rev 1.0
interface axis_if #(
  parameter type DATA_TYPE = logic [7:0]
);

  DATA_TYPE dat;
  logic     vld;
  logic     rdy;
  logic     lst;

  modport master (output dat, output vld, output lst, input rdy);
  modport slave  (input dat, input vld, input lst, output rdy);

endinterface
`default_nettype wire

// File: rtl/chunk_serialize.sv
`default_nettype none
// chunk_serialize: splits each chunk_t into bytes, LSB first, one byte per clock.
// Rev 1.0
module chunk_serialize
  import pixel_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  axis_if.slave  axis_i,
  axis_if.master axis_o
);

  localparam int CHUNK_W     = $bits(chunk_t);
  localparam int CHUNK_BYTES = CHUNK_W / 8;
  localparam int CNT_W       = $clog2(CHUNK_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNK_BYTES - 1);

  logic [CHUNK_W-1:0] sr;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               chunk_lst;

  logic at_last;
  logic in_rdy;
  logic in_xfer;
  logic out_xfer;

  assign at_last  = (cnt == LAST_IDX);
  // Accepting on the final byte's transfer keeps the byte stream bubble-free.
  assign in_rdy   = !rst && (!busy || (axis_o.rdy && at_last));
  assign in_xfer  = axis_i.vld && in_rdy;
  assign out_xfer = busy && axis_o.rdy;

  assign axis_i.rdy = in_rdy;
  assign axis_o.vld = busy;
  assign axis_o.dat = sr[7:0];
  assign axis_o.lst = busy && chunk_lst && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      chunk_lst <= 1'b0;
    end else if (in_xfer) begin
      sr        <= axis_i.dat;
      cnt       <= '0;
      busy      <= 1'b1;
      chunk_lst <= axis_i.lst;
    end else if (out_xfer) begin
      if (at_last) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        sr  <= sr >> 8;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chunk_serialize.sv
`default_nettype none
// tb_chunk_serialize: directed and random-handshake checks of chunk_serialize.
// Rev 1.0
module tb_chunk_serialize;
  import pixel_pkg::*;

  logic clk;
  logic rst;

  axis_if #(.DATA_TYPE(chunk_t))     in_if ();
  axis_if #(.DATA_TYPE(logic [7:0])) out_if ();

  chunk_serialize dut (
    .clk    (clk),
    .rst    (rst),
    .axis_i (in_if),
    .axis_o (out_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] out_dat [$];
  logic       out_lst [$];
  logic       out_irdy [$];
  int         out_cyc [$];
  int         in_cyc [$];

  logic [7:0] exp_dat [$];
  logic       exp_lst [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after posedge, so a handshake seen here fires at the next edge.
  always @(negedge clk) begin
    if (!rst && out_if.vld && out_if.rdy) begin
      out_dat.push_back(out_if.dat);
      out_lst.push_back(out_if.lst);
      out_irdy.push_back(in_if.rdy);
      out_cyc.push_back(cyc);
    end
    if (!rst && in_if.vld && in_if.rdy) in_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [95:0] mk_chunk(input logic [7:0] base);
    logic [95:0] d;
    for (int k = 0; k < 12; k++) d[8*k +: 8] = base + 8'(k);
    return d;
  endfunction

  task automatic clear_queues();
    out_dat.delete(); out_lst.delete(); out_irdy.delete();
    out_cyc.delete(); in_cyc.delete();
  endtask

  task automatic send_chunk(input logic [95:0] d, input logic l);
    int k = 0;
    in_if.dat = d;
    in_if.lst = l;
    in_if.vld = 1'b1;
    @(negedge clk);
    while (!in_if.rdy && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    in_if.vld = 1'b0;
    check("send_accept", 32'(k < 400), 32'd1);
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int k = 0;
    while (out_dat.size() < n && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_bytes", 32'(out_dat.size() >= n), 32'd1);
  endtask

  task automatic check_seq(input string tag, input logic [7:0] base, input int first, input int lst_idx);
    for (int i = 0; i < 12; i++) begin
      check({tag, "_dat"}, 32'(out_dat[first+i]), 32'(base + 8'(i)));
      check({tag, "_lst"}, 32'(out_lst[first+i]), 32'(first + i == lst_idx));
    end
  endtask

  initial begin
    int k;
    logic [95:0] d;
    logic        l;
    bit          rand_on;

    rst        = 1'b1;
    in_if.vld  = 1'b0;
    in_if.lst  = 1'b0;
    in_if.dat  = '0;
    out_if.rdy = 1'b1;

    // Reset values
    repeat (3) begin
      @(negedge clk);
      check("rst_vld", 32'(out_if.vld), 32'd0);
      check("rst_dat", 32'(out_if.dat), 32'd0);
      check("rst_lst", 32'(out_if.lst), 32'd0);
      check("rst_irdy", 32'(in_if.rdy), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("irdy_after_rst", 32'(in_if.rdy), 32'd1);

    // Single chunk, full throughput
    @(posedge clk); #1;
    clear_queues();
    send_chunk(mk_chunk(8'h00), 1'b1);
    wait_bytes(12, 100);
    check_seq("single", 8'h00, 0, 11);
    check("single_latency", 32'(out_cyc[0] - in_cyc[0]), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("single_gap", 32'(out_cyc[i] - out_cyc[0]), 32'(i));
      check("single_irdy", 32'(out_irdy[i]), 32'(i == 11));
    end

    // Back-to-back chunks
    repeat (2) @(posedge clk); #1;
    clear_queues();
    send_chunk(mk_chunk(8'h00), 1'b1);
    send_chunk(mk_chunk(8'h10), 1'b0);
    wait_bytes(24, 100);
    check_seq("b2b_a", 8'h00, 0, 11);
    check_seq("b2b_b", 8'h10, 12, 11);
    for (int i = 0; i < 24; i++)
      check("b2b_gap", 32'(out_cyc[i] - out_cyc[0]), 32'(i));
    check("b2b_accept", 32'(in_cyc[1]), 32'(out_cyc[11]));

    // Backpressure stall on byte 0x04
    repeat (2) @(posedge clk); #1;
    clear_queues();
    send_chunk(mk_chunk(8'h00), 1'b1);
    k = 0;
    while (!(out_if.vld && out_if.dat == 8'h04) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("bp_reach", 32'(out_if.dat), 32'h04);
    out_if.rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_vld", 32'(out_if.vld), 32'd1);
      check("bp_dat", 32'(out_if.dat), 32'h04);
      @(posedge clk); #1;
    end
    out_if.rdy = 1'b1;
    wait_bytes(12, 100);
    check_seq("bp", 8'h00, 0, 11);
    repeat (3) @(posedge clk); #1;
    check("bp_count", 32'(out_dat.size()), 32'd12);

    // Reset in the middle of a chunk
    clear_queues();
    send_chunk(mk_chunk(8'h00), 1'b1);
    wait_bytes(6, 50);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_irdy", 32'(in_if.rdy), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_vld", 32'(out_if.vld), 32'd0);
    check("mid_rst_dat", 32'(out_if.dat), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_queues();
    @(negedge clk);
    check("mid_rst_irdy_rel", 32'(in_if.rdy), 32'd1);
    @(posedge clk); #1;
    send_chunk(mk_chunk(8'h20), 1'b1);
    wait_bytes(12, 100);
    check_seq("post_rst", 8'h20, 0, 11);
    repeat (3) @(posedge clk); #1;
    check("post_rst_count", 32'(out_dat.size()), 32'd12);

    // Random valid/ready over 100 chunks
    clear_queues();
    rand_on = 1'b1;
    fork
      begin
        for (int c = 0; c < 100; c++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          d = {$urandom, $urandom, $urandom};
          l = 1'($urandom_range(0, 1));
          for (int b = 0; b < 12; b++) begin
            exp_dat.push_back(d[8*b +: 8]);
            exp_lst.push_back(l && (b == 11));
          end
          send_chunk(d, l);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          out_if.rdy = 1'($urandom_range(0, 1));
        end
      end
    join
    out_if.rdy = 1'b1;
    wait_bytes(1200, 3000);
    for (int i = 0; i < 1200 && i < out_dat.size(); i++) begin
      check("rand_dat", 32'(out_dat[i]), 32'(exp_dat[i]));
      check("rand_lst", 32'(out_lst[i]), 32'(exp_lst[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
